// File: rtl/csi_pkg.sv
// Shared definitions for the CSI-2 payload CRC-16 datapath: CRC constants,
// the framing FSM state type and a single-byte reflected CRC update.
package csi_pkg;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_SEED      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESULT
  } csi_state_e;

  // One byte through the reflected CRC-16 register, LSB of the byte first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC16_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16_stream_if.sv
// Beat and result bundle for csi_crc16_stream.
// slave: the CRC engine side; master: the source/sink that drives beats and
// consumes results.
interface csi_crc16_stream_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned LEN_W = 16
);
  localparam int unsigned SelW = (LANES > 1) ? $clog2(LANES) : 1;

  // Beat side
  logic                 check_en_i;
  logic [8*LANES-1:0]   data_i;
  logic                 valid_i;
  logic                 sop_i;
  logic                 eop_i;
  logic [SelW-1:0]      last_sel_i;
  logic [15:0]          expected_crc_i;
  logic                 ready_o;

  // Result side
  logic [15:0]          crc_o;
  logic [LEN_W-1:0]     len_o;
  logic                 crc_err_o;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic                 abort_o;

  modport slave (
    input  check_en_i, data_i, valid_i, sop_i, eop_i, last_sel_i, expected_crc_i, res_ready_i,
    output ready_o, crc_o, len_o, crc_err_o, res_valid_o, abort_o
  );

  modport master (
    output check_en_i, data_i, valid_i, sop_i, eop_i, last_sel_i, expected_crc_i, res_ready_i,
    input  ready_o, crc_o, len_o, crc_err_o, res_valid_o, abort_o
  );

endinterface

// File: rtl/csi_crc16_byte_stage.sv
// Single-byte combinational CRC-16 update; chained once per lane.
module csi_crc16_byte_stage
  import csi_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i);

endmodule

// File: rtl/csi_crc16_stream.sv
// Streaming CSI-2 payload CRC-16 engine, LANES bytes per beat, sop/eop framed,
// partial last beat via last_sel_i. Produces CRC, byte count and an optional
// check against the footer CRC.
// Optional feature: define CSI_CRC16_ERRCNT_EN to add err_clr_i / err_cnt_o,
// a saturating count of results reported with crc_err_o=1.
module csi_crc16_stream
  import csi_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter logic [15:0] SEED  = CRC16_SEED,
  parameter int unsigned LEN_W = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
`ifdef CSI_CRC16_ERRCNT_EN
  input  logic        err_clr_i,
  output logic [15:0] err_cnt_o,
`endif
  csi_crc16_stream_if.slave bus
);

  localparam int unsigned SelW = (LANES > 1) ? $clog2(LANES) : 1;

  csi_state_e       r_state, w_state_next;

  logic [15:0]      r_crc;
  logic [15:0]      w_base_crc;
  logic [15:0]      w_fold_crc;
  logic [15:0]      w_after [LANES];

  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_base;
  logic [LEN_W-1:0] w_len_next;
  logic [LEN_W:0]   w_len_sum;
  logic [3:0]       w_beat_bytes;

  logic             r_check_en;
  logic             w_check_eff;

  logic             w_accept;
  logic             w_load;
  logic             w_done;
  logic             w_abort;
  logic             r_abort;

  logic [15:0]      r_res_crc;
  logic [LEN_W-1:0] r_res_len;
  logic             r_res_err;

  assign bus.ready_o = (r_state != RESULT) | bus.res_ready_i;
  assign w_accept    = bus.valid_i & bus.ready_o;

  // A sop beat always starts from the preset, regardless of what was in flight.
  assign w_base_crc  = bus.sop_i ? SEED : r_crc;
  assign w_len_base  = bus.sop_i ? '0 : r_len;
  assign w_check_eff = bus.sop_i ? bus.check_en_i : r_check_en;

  for (genvar k = 0; k < LANES; k++) begin : g_stage
    logic [15:0] w_crc_in;
    logic [15:0] w_crc_out;

    if (k == 0) begin : g_first
      assign w_crc_in = w_base_crc;
    end else begin : g_next
      assign w_crc_in = g_stage[k-1].w_crc_out;
    end

    csi_crc16_byte_stage u_stage (
      .crc_i  (w_crc_in),
      .data_i (bus.data_i[8*k +: 8]),
      .crc_o  (w_crc_out)
    );

    assign w_after[k] = w_crc_out;
  end

  // Pick the CRC after the last valid byte of the beat and count those bytes.
  always_comb begin
    w_fold_crc   = w_after[LANES-1];
    w_beat_bytes = 4'(LANES);
    if (bus.eop_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.last_sel_i == SelW'(k)) begin
          w_fold_crc   = w_after[k];
          w_beat_bytes = 4'(k + 1);
        end
      end
    end
  end

  // Saturating byte counter; never wraps back to small values.
  always_comb begin
    w_len_sum  = {1'b0, w_len_base} + (LEN_W+1)'(w_beat_bytes);
    w_len_next = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
  end

  // Framing FSM next state plus load/complete/abort strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Beats without sop outside a packet are dropped.
        if (w_accept && bus.sop_i) begin
          w_load       = 1'b1;
          w_done       = bus.eop_i;
          w_state_next = bus.eop_i ? RESULT : ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_accept) begin
          w_load  = 1'b1;
          w_done  = bus.eop_i;
          w_abort = bus.sop_i;
          if (bus.eop_i) begin
            w_state_next = RESULT;
          end
        end
      end
      RESULT: begin
        // Any accepted beat here implies the result handshake this cycle.
        if (bus.res_ready_i) begin
          w_state_next = IDLE;
        end
        if (w_accept && bus.sop_i) begin
          w_load       = 1'b1;
          w_done       = bus.eop_i;
          w_state_next = bus.eop_i ? RESULT : ACTIVE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Running CRC, length and check-mode latch for the packet in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_crc      <= SEED;
      r_len      <= '0;
      r_check_en <= 1'b0;
    end else if (w_load) begin
      r_crc <= w_fold_crc;
      r_len <= w_len_next;
      if (bus.sop_i) begin
        r_check_en <= bus.check_en_i;
      end
    end
  end

  // Result registers, only written on packet completion so they hold under backpressure.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_res_crc <= '0;
      r_res_len <= '0;
      r_res_err <= 1'b0;
    end else if (w_done) begin
      r_res_crc <= w_fold_crc;
      r_res_len <= w_len_next;
      r_res_err <= w_check_eff & (w_fold_crc != bus.expected_crc_i);
    end
  end

  // Registered abort pulse for a sop that restarts an unfinished packet.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_abort;
    end
  end

  assign bus.crc_o       = r_res_crc;
  assign bus.len_o       = r_res_len;
  assign bus.crc_err_o   = r_res_err;
  assign bus.res_valid_o = (r_state == RESULT);
  assign bus.abort_o     = r_abort;

`ifdef CSI_CRC16_ERRCNT_EN
  logic        w_res_hs;
  logic [15:0] r_err_cnt;

  assign w_res_hs = (r_state == RESULT) & bus.res_ready_i;

  // Saturating error-result counter; clear has priority over increment.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_res_hs && r_res_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_csi_crc16_stream.sv
// Self-checking bench for csi_crc16_stream (LANES=4): scoreboard of expected
// results filled by the stimulus, drained by a monitor on result handshakes.
module tb_csi_crc16_stream;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [15:0] crc;
    logic [15:0] len;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rr_mode;
  int   abort_seen;
  int   abort_exp;
  exp_t sb[$];
  byte_q_t vec_q;

  logic        hold_prev;
  logic [15:0] hold_crc;
  logic [15:0] hold_len;
  logic        hold_err;

`ifdef CSI_CRC16_ERRCNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  csi_crc16_stream_if #(.LANES(4), .LEN_W(16)) bus ();

  csi_crc16_stream #(
    .LANES (4),
    .SEED  (16'hFFFF),
    .LEN_W (16)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (rst_n),
`ifdef CSI_CRC16_ERRCNT_EN
    .err_clr_i (err_clr),
    .err_cnt_o (err_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Bit-serial CRC-16/0x8408 over a byte list, LSB of each byte first, no final XOR.
  function automatic logic [15:0] model_crc(input byte_q_t b);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
      end
    end
    return c;
  endfunction

  function automatic void push_exp(input logic [15:0] crc, input int len, input logic err);
    exp_t e;
    e.crc = crc;
    e.len = 16'(len);
    e.err = err;
    sb.push_back(e);
  endfunction

  // Result sink readiness: 0 random, 1 held low, 2 always high.
  initial begin
    bus.res_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.res_ready_i = ($urandom_range(0, 3) != 0);
        1:       bus.res_ready_i = 1'b0;
        default: bus.res_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: handshake-driven scoreboard, hold stability, ready rule, abort pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("ready_rule", 32'(bus.ready_o), 32'(!bus.res_valid_o || bus.res_ready_i));
      if (hold_prev && bus.res_valid_o) begin
        check("hold_crc", 32'(bus.crc_o), 32'(hold_crc));
        check("hold_len", 32'(bus.len_o), 32'(hold_len));
        check("hold_err", 32'(bus.crc_err_o), 32'(hold_err));
      end
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got crc %h len %0d required no result",
                   bus.crc_o, bus.len_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("crc", 32'(bus.crc_o), 32'(e.crc));
          check("len", 32'(bus.len_o), 32'(e.len));
          check("crc_err", 32'(bus.crc_err_o), 32'(e.err));
        end
      end
      if (bus.abort_o) abort_seen++;
      hold_prev = bus.res_valid_o && !bus.res_ready_i;
      hold_crc  = bus.crc_o;
      hold_len  = bus.len_o;
      hold_err  = bus.crc_err_o;
    end
  end

  task automatic idle_inputs();
    bus.valid_i        = 1'b0;
    bus.data_i         = $urandom;
    bus.sop_i          = 1'($urandom);
    bus.eop_i          = 1'($urandom);
    bus.last_sel_i     = 2'($urandom);
    bus.check_en_i     = 1'($urandom);
    bus.expected_crc_i = 16'($urandom);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [31:0] d, input bit s, input bit e,
                            input logic [1:0] sel, input bit chk, input logic [15:0] exp);
    bit acc;
    int guard;
    guard              = 0;
    bus.valid_i        = 1'b1;
    bus.data_i         = d;
    bus.sop_i          = s;
    bus.eop_i          = e;
    bus.last_sel_i     = sel;
    bus.check_en_i     = s ? chk : 1'($urandom);
    bus.expected_crc_i = e ? exp : 16'($urandom);
    forever begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_accept: got no ready in %0d cycles required acceptance", guard);
        break;
      end
    end
    idle_inputs();
  endtask

  // Send a packet; max_beats >= 0 truncates it (no eop) after that many beats.
  task automatic send_pkt(input byte_q_t b, input bit chk, input logic [15:0] exp,
                          input int max_beats, input bit bubbles);
    int n;
    int nbeats;
    n      = b.size();
    nbeats = (n + 3) / 4;
    for (int bt = 0; bt < nbeats; bt++) begin
      logic [31:0] d;
      bit          last;
      if (max_beats >= 0 && bt >= max_beats) break;
      d = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (bt * 4 + k < n) d[8*k +: 8] = b[bt*4+k];
      end
      last = (bt == nbeats - 1);
      drive_beat(d, bt == 0, last, last ? 2'((n - 1) % 4) : 2'($urandom), chk, exp);
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, "_res_valid"}, 32'(bus.res_valid_o), 32'd0);
    check({tag, "_crc"}, 32'(bus.crc_o), 32'd0);
    check({tag, "_len"}, 32'(bus.len_o), 32'd0);
    check({tag, "_crc_err"}, 32'(bus.crc_err_o), 32'd0);
    check({tag, "_abort"}, 32'(bus.abort_o), 32'd0);
  endtask

  initial begin
    byte_q_t b;
    byte_q_t a;
    logic [15:0] c;
    logic [15:0] ex;
    bit          chk;
    bit          bad;
    int          n;

    checks     = 0;
    errors     = 0;
    rr_mode    = 2;
    abort_seen = 0;
    abort_exp  = 0;
    hold_prev  = 1'b0;
    vec_q = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
              8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
`ifdef CSI_CRC16_ERRCNT_EN
    err_clr = 1'b0;
`endif
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
`ifdef CSI_CRC16_ERRCNT_EN
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference vector, full beats, check mode with the right footer.
    push_exp(16'h00F0, 24, 1'b0);
    send_pkt(vec_q, 1'b1, 16'h00F0, -1, 1'b0);
    @(negedge clk);
    check("latency_res_valid", 32'(bus.res_valid_o), 32'd1);
    @(posedge clk);
    #1;
    // Wrong footer flags an error; generate mode never does.
    rr_mode = 0;
    push_exp(16'h00F0, 24, 1'b1);
    send_pkt(vec_q, 1'b1, 16'h00F1, -1, 1'b1);
    push_exp(16'h00F0, 24, 1'b0);
    send_pkt(vec_q, 1'b0, 16'h1234, -1, 1'b1);

    // Partial last beat: 22 bytes, two random pad lanes.
    b.delete();
    for (int i = 0; i < 22; i++) b.push_back(vec_q[i]);
    push_exp(model_crc(b), 22, 1'b0);
    send_pkt(b, 1'b0, 16'h0000, -1, 1'b1);

    // Stray beat without sop outside a packet is dropped.
    drain();
    drive_beat(32'($urandom), 1'b0, 1'b1, 2'd3, 1'b1, 16'h0000);

    // Randomized traffic with bubbles and random sink readiness.
    for (int p = 0; p < 25; p++) begin
      n   = $urandom_range(1, 40);
      b   = rand_bytes(n);
      c   = model_crc(b);
      chk = 1'($urandom);
      bad = 1'($urandom);
      ex  = bad ? (c ^ 16'($urandom_range(1, 65535))) : c;
      push_exp(c, n, chk & bad);
      send_pkt(b, chk, ex, -1, 1'($urandom));
    end

    // Backpressure: result held 5 cycles while the next packet waits.
    drain();
    rr_mode = 1;
    push_exp(16'h00F0, 24, 1'b0);
    send_pkt(vec_q, 1'b0, 16'h0000, -1, 1'b0);
    b = rand_bytes(13);
    push_exp(model_crc(b), 13, 1'b0);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_res_valid", 32'(bus.res_valid_o), 32'd1);
          check("bp_ready", 32'(bus.ready_o), 32'd0);
        end
        rr_mode = 2;
      end
      begin
        send_pkt(b, 1'b0, 16'h0000, -1, 1'b1);
      end
    join
    rr_mode = 0;

    // Abort: a new sop on the third beat of an unfinished packet.
    a = rand_bytes(16);
    b = rand_bytes(19);
    push_exp(model_crc(b), 19, 1'b0);
    send_pkt(a, 1'b1, 16'h0000, 2, 1'b0);
    send_pkt(b, 1'b1, model_crc(b), -1, 1'b0);
    abort_exp++;

    // Reset in the middle of a packet, then a clean packet.
    drain();
    rr_mode = 2;
    send_pkt(vec_q, 1'b1, 16'h00F0, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(16'h00F0, 24, 1'b0);
    send_pkt(vec_q, 1'b1, 16'h00F0, -1, 1'b1);
    drain();

`ifdef CSI_CRC16_ERRCNT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    rr_mode = 0;
    for (int p = 0; p < 3; p++) begin
      push_exp(16'h00F0, 24, 1'b1);
      send_pkt(vec_q, 1'b1, 16'h00F1, -1, 1'b1);
    end
    drain();
    @(negedge clk);
    check("err_cnt", 32'(err_cnt), 32'd3);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

    drain();
    repeat (3) @(posedge clk);
    check("abort_pulses", 32'(abort_seen), 32'(abort_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi_crc16_stream.md
# csi_crc16_stream

Parametrised, streaming CSI-2 payload CRC-16 engine for the CSI RX path. It accepts LANES bytes per cycle under a valid/ready handshake, with packet framing (sop/eop) and a partial final beat. On the end of each packet it produces the CRC and the byte count. In check mode it compares the CRC against the packet-footer CRC and flags mismatches. It sits between the lane merger and the long-packet payload sink, and replaces the fixed 4-byte, unframed CRC datapath.

## Interface
Parameters:
- LANES, default 4: bytes per beat; legal values 1, 2, 4, 8.
- SEED, default 16'hFFFF: CRC preset loaded at every sop.
- LEN_W, default 16: width of the byte counter.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- check_en_i  in  1  1 = compare against expected_crc_i; 0 = generate only. Sampled on the sop beat.
- data_i  in  8*LANES  payload beat; byte k is data_i[8k+7:8k]; byte 0 is first in time.
- valid_i  in  1  beat valid.
- sop_i  in  1  first beat of a packet.
- eop_i  in  1  last beat of a packet.
- last_sel_i  in  $clog2(LANES) (min 1)  number of valid bytes on the eop beat minus 1; ignored when eop_i=0.
- expected_crc_i  in  16  footer CRC; sampled on the eop beat.
- ready_o  out  1  beat accepted when valid_i & ready_o.
- crc_o  out  16  final CRC.
- len_o  out  LEN_W  payload byte count of the finished packet.
- crc_err_o  out  1  mismatch flag; valid only with res_valid_o and check mode.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumed when res_valid_o & res_ready_i.
- abort_o  out  1  one-cycle pulse when a packet is restarted by sop without a prior eop.

## Operation
- CRC definition: polynomial x^16+x^12+x^5+1, reflected form 0x8408. Each byte is processed LSB first. The register is preset to SEED. There is no final XOR. crc_o bit 0 is the first transmitted footer bit.
- Per beat: the bytes are folded in order 0..n-1 through a cascade of LANES single-byte update stages. On the eop beat, only the first last_sel_i+1 bytes are folded; the remaining bytes are don't-care.
- States:
  - IDLE: waiting for sop.
  - ACTIVE: accumulating beats.
  - RESULT: result held until res_ready_i.
- IDLE → ACTIVE on an accepted beat with sop_i=1 and eop_i=0.
- IDLE → RESULT on an accepted beat with sop_i=1 and eop_i=1 (single-beat packet).
- In IDLE, accepted beats with sop_i=0 are dropped.
- ACTIVE → RESULT on an accepted eop beat.
- An accepted sop beat in ACTIVE pulses abort_o, reseeds the CRC, restarts len, and stays in (or goes to) the new packet path.
- RESULT → IDLE on result handshake. If an accepted sop beat occurs in the same cycle, the next state is ACTIVE, or RESULT again for a single-beat packet.
- len counts accepted payload bytes. It saturates at all-ones and does not wrap.
- crc_err_o = check_en (as latched at sop) & (crc ≠ expected_crc_i as latched at eop).

## Timing
- Reset values: ready_o=1, res_valid_o=0, crc_o=16'h0000, len_o=0, crc_err_o=0, abort_o=0. State is IDLE and the CRC register holds SEED.
- Latency: res_valid_o rises the cycle after the accepted eop beat.
- ready_o = (state≠RESULT) | res_ready_i. This gives full throughput of one beat per cycle when the sink is always ready.
- crc_o, len_o and crc_err_o are stable while res_valid_o=1 and res_ready_i=0.
- valid_i=0 cycles inside a packet are bubbles; state and CRC are held.
- A reset assertion mid-packet discards the packet immediately (asynchronous). There is no result and no abort pulse.
- Combinational depth: LANES byte stages. LANES=8 must close timing at the CSI byte clock.

## Configuration
- CSI_CRC16_ERRCNT_EN defined: adds the output err_cnt_o (16 bits). It is a saturating count of results with crc_err_o=1, incremented on the result handshake, reset to 0, and cleared by the added input err_clr_i (clear wins over increment).
- Macro not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package csi_pkg holds:
  - CRC16_POLY_REFL = 16'h8408 and CRC16_SEED = 16'hFFFF.
  - The state enum typedef (IDLE, ACTIVE, RESULT).
  - The function crc16_byte(crc, byte).
- One sub-module, csi_crc16_byte_stage: a single-byte combinational update, instantiated LANES times in a generate chain. Stage k outputs the running CRC after byte k. A mux driven by last_sel_i picks the CRC after stage n-1.

## Test plan
- Reference vector, LANES=4, last_sel_i=3 on all 6 beats:
  - Stimulus: bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
  - Expected: crc_o=16'h00F0, len_o=24.
  - Check mode with expected 16'h00F0 → crc_err_o=0; with 16'h00F1 → crc_err_o=1.
- Same 24 bytes at LANES=1, 2 and 8 → crc_o=16'h00F0 in every case. Cycles from sop to res_valid_o = 24/LANES.
- Partial last beat, LANES=4:
  - Stimulus: 22 bytes (the vector minus its final 00 01), with last_sel_i=1 on beat 6; lanes 2–3 are driven with random data.
  - Expected: the result matches a bit-serial model, and len_o=22.
- Backpressure and bubbles:
  - Stimulus: res_ready_i held low for 5 cycles after the result; random valid_i gaps throughout.
  - Expected: ready_o=0 while the result is pending, outputs are stable, and no beat is lost. A back-to-back next packet gives the correct second CRC.
- Abort: sop arrives at beat 3 of an unfinished packet → abort_o pulses for 1 cycle, and the new packet's CRC equals a standalone computation.
- Reset mid-packet at beat 2 → all outputs return to their reset values. A following clean packet gives 16'h00F0. With CSI_CRC16_ERRCNT_EN, 3 bad packets give err_cnt_o=3, and err_clr_i returns it to 0.
